// File: rtl/game_pkg.sv
// Shared definitions for the fighting-game blocks: state encoding, field
// widths and the saturating health decrement. The controller, display,
// LED and sprite blocks all import this package.
package game_pkg;

  localparam int GAME_STATE_W = 3;
  localparam int HEALTH_W     = 3;
  localparam int SECS_W       = 7;

  typedef enum logic [GAME_STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_FIGHT     = 3'd2,
    S_P1_WIN    = 3'd3,
    S_P2_WIN    = 3'd4,
    S_EQ        = 3'd5
  } game_state_e;

  // One hit removes one health point; an empty bar stays empty.
  function automatic logic [HEALTH_W-1:0] health_dec(input logic [HEALTH_W-1:0] h);
    return (h == '0) ? h : h - HEALTH_W'(1);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second strobe generator. Counts 0..CLK_HZ-1 and raises tick for the
// single cycle in which the counter sits at its last value, so the strobe
// lands on the edge where the count wraps. clr restarts a full second.
// CLK_HZ must be at least 2.
module sec_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_HZ - 2);

  logic [CNT_W-1:0] cnt;

  // Free-running second counter with a registered strobe at the wrap value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/match_controller.sv
// Top-level match sequencer: IDLE -> COUNTDOWN -> FIGHT -> result -> IDLE.
// Owns both health counters and the seconds-remaining display value.
// Build option: define MATCH_TIMEOUT_EN to enable the FIGHT time limit;
// without it a fight ends only on a knockout and secs_left stays 0.
module match_controller
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int COUNTDOWN_S = 3,
  parameter int FIGHT_S     = 99,
  parameter int RESULT_S    = 5,
  parameter int MAX_HEALTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    p1_hit,
  input  logic                    p2_hit,
  output logic [GAME_STATE_W-1:0] game_state,
  output logic [HEALTH_W-1:0]     p1_health,
  output logic [HEALTH_W-1:0]     p2_health,
  output logic [SECS_W-1:0]       secs_left,
  output logic                    tick
);

  localparam logic [HEALTH_W-1:0] HP_FULL = HEALTH_W'(MAX_HEALTH);

  game_state_e         state, nxt_state;
  logic [HEALTH_W-1:0] nxt_p1, nxt_p2, hit_p1, hit_p2;
  logic [SECS_W-1:0]   nxt_secs;
  logic                last_sec;
  logic                clr;

  assign game_state = state;
  assign last_sec   = tick && (secs_left == SECS_W'(1));
  // Every state entry restarts the second counter so the first second is full.
  assign clr        = (nxt_state != state);

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Next-state, health and countdown decisions for the coming edge.
  always_comb begin
    nxt_state = state;
    nxt_p1    = p1_health;
    nxt_p2    = p2_health;
    nxt_secs  = secs_left;
    hit_p1    = p1_hit ? health_dec(p1_health) : p1_health;
    hit_p2    = p2_hit ? health_dec(p2_health) : p2_health;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_COUNTDOWN;
          nxt_secs  = SECS_W'(COUNTDOWN_S);
          nxt_p1    = HP_FULL;
          nxt_p2    = HP_FULL;
        end
      end
      S_COUNTDOWN: begin
        if (last_sec) begin
          nxt_state = S_FIGHT;
`ifdef MATCH_TIMEOUT_EN
          nxt_secs  = SECS_W'(FIGHT_S);
`else
          nxt_secs  = '0;
`endif
        end else if (tick) begin
          nxt_secs = secs_left - SECS_W'(1);
        end
      end
      S_FIGHT: begin
        nxt_p1 = hit_p1;
        nxt_p2 = hit_p2;
        // Knockout is judged on post-hit values and beats a same-cycle timeout.
        if (hit_p1 == '0 && hit_p2 == '0) begin
          nxt_state = S_EQ;
          nxt_secs  = SECS_W'(RESULT_S);
        end else if (hit_p1 == '0) begin
          nxt_state = S_P2_WIN;
          nxt_secs  = SECS_W'(RESULT_S);
        end else if (hit_p2 == '0) begin
          nxt_state = S_P1_WIN;
          nxt_secs  = SECS_W'(RESULT_S);
        end
`ifdef MATCH_TIMEOUT_EN
        else if (last_sec) begin
          nxt_secs = SECS_W'(RESULT_S);
          if (hit_p1 > hit_p2)      nxt_state = S_P1_WIN;
          else if (hit_p1 < hit_p2) nxt_state = S_P2_WIN;
          else                      nxt_state = S_EQ;
        end else if (tick) begin
          nxt_secs = secs_left - SECS_W'(1);
        end
`endif
      end
      S_P1_WIN, S_P2_WIN, S_EQ: begin
        if (last_sec) begin
          nxt_state = S_IDLE;
          nxt_secs  = '0;
        end else if (tick) begin
          nxt_secs = secs_left - SECS_W'(1);
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_secs  = '0;
      end
    endcase
  end

  // Registered match state, healths and seconds display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      p1_health <= HP_FULL;
      p2_health <= HP_FULL;
      secs_left <= '0;
    end else begin
      state     <= nxt_state;
      p1_health <= nxt_p1;
      p2_health <= nxt_p2;
      secs_left <= nxt_secs;
    end
  end

endmodule
